distance_uart_reporter: RTL and testbench

//  Downstream of the ultrasonic ranging stage: takes each new distance sample (cm),

---
 rtl/distance_uart_reporter_if.sv | 25 ++
 rtl/distance_uart_reporter.sv | 198 +++++++++++++++++++
 tb/tb_distance_uart_reporter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/distance_uart_reporter_if.sv
// Sample-in / serial-out bundle for distance_uart_reporter.
// The master drives samples; the slave, the reporter itself, drives the UART line and status.
interface distance_uart_reporter_if;
    logic [15:0] distance_cm;
    logic        distance_valid;
    logic        tx;
    logic        busy;
    logic [7:0]  drop_count;

    modport master (
        output distance_cm,
        output distance_valid,
        input  tx,
        input  busy,
        input  drop_count
    );

    modport slave (
        input  distance_cm,
        input  distance_valid,
        output tx,
        output busy,
        output drop_count
    );
endinterface

// File: rtl/distance_uart_reporter.sv
// Converts each distance sample to five ASCII digits and sends "DDDDD cm\r\n" as 8N1 UART.
// One pending sample is buffered while a frame is in flight; overwrites are counted.
module distance_uart_reporter #(
    parameter int unsigned CLK_FREQ_HZ  = 12000000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
    input logic                     clk,
    input logic                     rst,
    distance_uart_reporter_if.slave bus
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StConvert,
        StStart,
        StData,
        StStop
    } state_e;

    state_e        state_q;
    logic          tx_q;
    logic          busy_q;
    logic [7:0]    drop_q;
    logic          pend_flag_q;
    logic [15:0]   pend_val_q;
    logic [CW-1:0] bit_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [3:0]    byte_idx_q;
    logic [4:0]    conv_cnt_q;
    logic [15:0]   bin_q;
    logic [19:0]   bcd_q;

    logic [15:0] adj;
    logic [19:0] bcd_shift;
    logic [15:0] bin_shift;
    logic [7:0]  cur_byte;
    logic [7:0]  drop_inc;
    logic [2:0]  next_bit_idx;
    logic        bit_last;
    logic        frame_end;

    // Double-dabble step. The top digit never reaches 5 before the final shift
    // (at most 3 after 15 shifts), so only the lower four digits need correcting.
    always_comb begin
        adj = bcd_q[15:0];
        for (int i = 0; i < 4; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_q[18:16], adj, bin_q[15]};
        bin_shift = {bin_q[14:0], 1'b0};
    end

    always_comb begin
        case (byte_idx_q)
            4'd0:    cur_byte = {4'h3, bcd_q[19:16]};
            4'd1:    cur_byte = {4'h3, bcd_q[15:12]};
            4'd2:    cur_byte = {4'h3, bcd_q[11:8]};
            4'd3:    cur_byte = {4'h3, bcd_q[7:4]};
            4'd4:    cur_byte = {4'h3, bcd_q[3:0]};
            4'd5:    cur_byte = 8'h20;
            4'd6:    cur_byte = 8'h63;
            4'd7:    cur_byte = 8'h6D;
            4'd8:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign drop_inc     = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    assign next_bit_idx = bit_idx_q + 3'd1;
    assign bit_last     = (bit_cnt_q == BIT_LAST);
    assign frame_end    = (state_q == StStop) && bit_last && (byte_idx_q == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            drop_q      <= 8'd0;
            pend_flag_q <= 1'b0;
            pend_val_q  <= 16'd0;
            bit_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 4'd0;
            conv_cnt_q  <= 5'd0;
            bin_q       <= 16'd0;
            bcd_q       <= 20'd0;
        end else begin
            // The frame-end edge resolves input and pending itself, below.
            if (busy_q && bus.distance_valid && !frame_end) begin
                pend_val_q  <= bus.distance_cm;
                pend_flag_q <= 1'b1;
                if (pend_flag_q) begin
                    drop_q <= drop_inc;
                end
            end

            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (bus.distance_valid) begin
                        bin_q      <= bus.distance_cm;
                        bcd_q      <= 20'd0;
                        conv_cnt_q <= 5'd0;
                        busy_q     <= 1'b1;
                        state_q    <= StConvert;
                    end
                end

                StConvert: begin
                    if (conv_cnt_q == 5'd16) begin
                        state_q    <= StStart;
                        tx_q       <= 1'b0;
                        bit_cnt_q  <= '0;
                        byte_idx_q <= 4'd0;
                    end else begin
                        bin_q      <= bin_shift;
                        bcd_q      <= bcd_shift;
                        conv_cnt_q <= conv_cnt_q + 5'd1;
                    end
                end

                StStart: begin
                    if (bit_last) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= cur_byte[0];
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                StData: begin
                    if (bit_last) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= next_bit_idx;
                            tx_q      <= cur_byte[next_bit_idx];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                StStop: begin
                    if (bit_last) begin
                        bit_cnt_q <= '0;
                        if (byte_idx_q == 4'd9) begin
                            byte_idx_q <= 4'd0;
                            if (bus.distance_valid) begin
                                // A fresh sample beats a stale pending one.
                                bin_q       <= bus.distance_cm;
                                bcd_q       <= 20'd0;
                                conv_cnt_q  <= 5'd0;
                                state_q     <= StConvert;
                                pend_flag_q <= 1'b0;
                                if (pend_flag_q) begin
                                    drop_q <= drop_inc;
                                end
                            end else if (pend_flag_q) begin
                                bin_q       <= pend_val_q;
                                bcd_q       <= 20'd0;
                                conv_cnt_q  <= 5'd0;
                                state_q     <= StConvert;
                                pend_flag_q <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            byte_idx_q <= byte_idx_q + 4'd1;
                            state_q    <= StStart;
                            tx_q       <= 1'b0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_distance_uart_reporter.sv
// Self-checking bench: transaction-level reference model plus a UART receiver that
// decodes tx and compares received frames against expected text.
module tb_distance_uart_reporter;

    localparam int CPB   = 4;
    localparam int FRAME = 100 * CPB;

    logic clk;
    logic rst;

    distance_uart_reporter_if bus ();

    distance_uart_reporter #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state (time measured in posedge count).
    int   cyc = 0;
    bit   m_busy = 0;
    int   m_start = 0;
    int   m_val = 0;
    bit   m_pend = 0;
    int   m_pval = 0;
    int   m_drop = 0;

    // Receiver state.
    bit         rx_act = 0;
    int         rx_t = 0;
    logic [7:0] rx_b;
    logic [7:0] rx_q[$];

    typedef struct {
        logic [15:0] value;
        string       text;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [7:0] model_char(int v, int i);
        int div[5] = '{10000, 1000, 100, 10, 1};
        if (i < 5) return 8'h30 + 8'((v / div[i]) % 10);
        if (i == 5) return 8'h20;
        if (i == 6) return 8'h63;
        if (i == 7) return 8'h6D;
        if (i == 8) return 8'h0D;
        return 8'h0A;
    endfunction

    function automatic logic exp_tx();
        int pos;
        int byt;
        int bitn;
        logic [7:0] ch;
        if (!m_busy || cyc < m_start || cyc >= m_start + FRAME) return 1'b1;
        pos  = (cyc - m_start) / CPB;
        byt  = pos / 10;
        bitn = pos % 10;
        if (bitn == 0) return 1'b0;
        if (bitn == 9) return 1'b1;
        ch = model_char(m_val, byt);
        return ch[bitn-1];
    endfunction

    function automatic void m_accept(int v);
        m_busy  = 1;
        m_val   = v;
        m_start = cyc + 17;
    endfunction

    function automatic void m_drop_inc();
        if (m_drop < 255) m_drop++;
    endfunction

    function automatic void model_edge(logic r, logic v, logic [15:0] d);
        cyc++;
        if (r) begin
            m_busy = 0;
            m_pend = 0;
            m_drop = 0;
        end else if (!m_busy) begin
            if (v) m_accept(int'(d));
        end else if (cyc == m_start + FRAME) begin
            if (v) begin
                if (m_pend) m_drop_inc();
                m_pend = 0;
                m_accept(int'(d));
            end else if (m_pend) begin
                m_pend = 0;
                m_accept(m_pval);
            end else begin
                m_busy = 0;
            end
        end else if (v) begin
            if (m_pend) m_drop_inc();
            m_pend = 1;
            m_pval = int'(d);
        end
    endfunction

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void rx_clear();
        rx_act = 0;
        rx_q.delete();
    endfunction

    function automatic void rx_sample(logic r);
        if (r) begin
            rx_clear();
        end else if (!rx_act) begin
            if (bus.tx == 1'b0) begin
                rx_act = 1;
                rx_t   = 0;
                rx_b   = 8'h00;
            end
        end else begin
            rx_t++;
            if (rx_t >= 6 && rx_t <= 34 && (rx_t % 4) == 2) rx_b[(rx_t-6)/4] = bus.tx;
            if (rx_t == 38) begin
                rx_q.push_back(rx_b);
                rx_act = 0;
            end
        end
    endfunction

    task automatic step(input logic r, input logic v, input logic [15:0] d);
        rst                = r;
        bus.distance_valid = v;
        bus.distance_cm    = d;
        @(posedge clk);
        model_edge(r, v, d);
        #1;
        check("tx", int'(bus.tx), int'(exp_tx()));
        check("busy", int'(bus.busy), int'(m_busy));
        check("drop_count", int'(bus.drop_count), m_drop);
        rx_sample(r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            step(1'b0, 1'b0, 16'd0);
            n++;
        end
        checks++;
        if (m_busy) begin
            errors++;
            $display("FAIL wait_idle timeout after %0d cycles", budget);
        end
    endtask

    task automatic check_frame(input string name, input string text);
        int bad = -1;
        checks++;
        if (rx_q.size() != text.len()) begin
            errors++;
            $display("FAIL %s received %0d bytes expected %0d", name, rx_q.size(), text.len());
        end else begin
            for (int i = 0; i < text.len(); i++) begin
                if (bad < 0 && rx_q[i] != text[i]) bad = i;
            end
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s byte %0d got=%02h expected=%02h", name, bad, rx_q[bad],
                         text[bad]);
            end
        end
        rx_clear();
    endtask

    initial begin
        vecs[0] = '{16'd123,   "00123 cm\r\n"};
        vecs[1] = '{16'd0,     "00000 cm\r\n"};
        vecs[2] = '{16'd65535, "65535 cm\r\n"};
        vecs[3] = '{16'd9,     "00009 cm\r\n"};

        rst                = 1'b1;
        bus.distance_valid = 1'b0;
        bus.distance_cm    = 16'd0;

        // Reset with strobes present: they must be ignored.
        step(1'b1, 1'b1, 16'd777);
        step(1'b1, 1'b1, 16'd888);
        check("reset_tx", int'(bus.tx), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_drop", int'(bus.drop_count), 0);
        idle(3);

        // Isolated samples, each followed by idle.
        for (int i = 0; i < 4; i++) begin
            rx_clear();
            step(1'b0, 1'b1, vecs[i].value);
            wait_idle(FRAME + 40);
            check_frame("table_frame", vecs[i].text);
            idle(5);
        end

        // Two strobes during a frame: first is overwritten, second follows back to back.
        rx_clear();
        step(1'b0, 1'b1, 16'd10);
        idle(5);
        step(1'b0, 1'b1, 16'd20);
        idle(5);
        step(1'b0, 1'b1, 16'd30);
        wait_idle(3 * FRAME);
        check_frame("overwrite_frames", "00010 cm\r\n00030 cm\r\n");
        check("overwrite_drop", int'(bus.drop_count), 1);
        idle(5);

        // Strobe exactly on the frame-end edge while a pending sample is held.
        rx_clear();
        step(1'b0, 1'b1, 16'd3);
        for (int i = 1; i <= 16 + FRAME; i++) step(1'b0, i == 100, 16'd5);
        step(1'b0, 1'b1, 16'd7);
        wait_idle(2 * FRAME);
        check_frame("frame_end_strobe", "00003 cm\r\n00007 cm\r\n");
        check("frame_end_drop", int'(bus.drop_count), 2);
        idle(5);

        // Reset in the middle of byte 3, then a clean frame.
        step(1'b0, 1'b1, 16'd99);
        idle(17 + 3 * 10 * CPB + 2 * CPB);
        step(1'b1, 1'b0, 16'd0);
        check("midreset_tx", int'(bus.tx), 1);
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_drop", int'(bus.drop_count), 0);
        idle(4);
        rx_clear();
        step(1'b0, 1'b1, 16'd42);
        wait_idle(FRAME + 40);
        check_frame("post_reset_frame", "00042 cm\r\n");

        // Random strobes checked cycle by cycle against the model.
        for (int i = 0; i < 6000; i++) begin
            step(1'b0, $urandom_range(0, 149) == 0, 16'($urandom));
        end
        wait_idle(3 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
